// File: rtl/bsg_cache_req_arbiter.sv
// Round-robin arbiter that shares one bsg_cache request/response port among several requesters.
// An in-order tag FIFO of requester IDs steers each cache response back to its issuer.
module bsg_cache_req_arbiter #(
  parameter int num_req_p         = 4,
  parameter int cache_pkt_width_p = 101,
  parameter int data_width_p      = 64,
  parameter int tag_fifo_els_p    = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [num_req_p*cache_pkt_width_p-1:0] req_pkt_i,
  input  logic [num_req_p-1:0]                   req_v_i,
  output logic [num_req_p-1:0]                   req_yumi_o,
  output logic [data_width_p-1:0]                resp_data_o,
  output logic [num_req_p-1:0]                   resp_v_o,
  input  logic [num_req_p-1:0]                   resp_yumi_i,
  output logic [cache_pkt_width_p-1:0]           cache_pkt_o,
  output logic                                   cache_v_o,
  input  logic                                   cache_yumi_i,
  input  logic [data_width_p-1:0]                cache_data_i,
  input  logic                                   cache_v_i,
  output logic                                   cache_yumi_o
);

  localparam int ID_W  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int PTR_W = $clog2(tag_fifo_els_p);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ID_W:0]    NUM_REQ   = (ID_W+1)'(num_req_p);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(num_req_p - 1);
  localparam logic [CNT_W-1:0] FIFO_ELS  = CNT_W'(tag_fifo_els_p);

  // Arbitration state
  logic [ID_W-1:0]  r_rr_ptr;
  logic             r_lock_v;
  logic [ID_W-1:0]  r_lock_id;

  // Tag FIFO state
  logic [ID_W-1:0]  r_tag_mem [tag_fifo_els_p];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [cache_pkt_width_p-1:0] w_pkt_slot [num_req_p];
  logic [ID_W:0]    w_cand;
  logic [ID_W-1:0]  w_rr_winner;
  logic             w_rr_found;
  logic [ID_W-1:0]  w_winner;
  logic [ID_W-1:0]  w_next_rr;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_issue_v;
  logic             w_push;
  logic             w_pop;
  logic [ID_W-1:0]  w_head;
  logic             w_resp_v;

  genvar gi;
  generate
    for (gi = 0; gi < num_req_p; gi++) begin : g_slot
      assign w_pkt_slot[gi] = req_pkt_i[gi*cache_pkt_width_p +: cache_pkt_width_p];
    end
  endgenerate

  // First valid requester at or after r_rr_ptr, wrapping modulo num_req_p.
  always_comb begin
    w_rr_winner = r_rr_ptr;
    w_rr_found  = 1'b0;
    w_cand      = '0;
    for (int k = 0; k < num_req_p; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_cand >= NUM_REQ) begin
        w_cand = w_cand - NUM_REQ;
      end
      if (!w_rr_found && req_v_i[w_cand[ID_W-1:0]]) begin
        w_rr_found  = 1'b1;
        w_rr_winner = w_cand[ID_W-1:0];
      end
    end
  end

  assign w_winner     = r_lock_v ? r_lock_id : w_rr_winner;
  assign w_next_rr    = (w_winner == LAST_ID) ? '0 : w_winner + ID_W'(1);
  assign w_fifo_full  = (r_count == FIFO_ELS);
  assign w_fifo_empty = (r_count == '0);

  // A full FIFO blocks issue even when a pop happens this cycle, keeping full off the pop path.
  assign w_issue_v = (r_lock_v | (|req_v_i)) & ~w_fifo_full & ~reset_i;
  assign w_push    = w_issue_v & cache_yumi_i;

  assign w_head   = r_tag_mem[r_rd_ptr];
  assign w_resp_v = cache_v_i & ~w_fifo_empty & ~reset_i;
  assign w_pop    = w_resp_v & resp_yumi_i[w_head];

  assign cache_v_o    = w_issue_v;
  assign cache_pkt_o  = reset_i ? '0 : w_pkt_slot[w_winner];
  assign cache_yumi_o = w_pop;
  assign resp_data_o  = reset_i ? '0 : cache_data_i;

  generate
    for (gi = 0; gi < num_req_p; gi++) begin : g_port
      assign req_yumi_o[gi] = w_push & (w_winner == ID_W'(gi));
      assign resp_v_o[gi]   = w_resp_v & (w_head == ID_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rr_ptr  <= '0;
      r_lock_v  <= 1'b0;
      r_lock_id <= '0;
    end else if (w_push) begin
      r_rr_ptr  <= w_next_rr;
      r_lock_v  <= 1'b0;
    end else if (w_issue_v) begin
      // Presented but not taken: pin the winner so the packet cannot change under the cache.
      r_lock_v  <= 1'b1;
      r_lock_id <= w_winner;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_tag_mem[r_wr_ptr] <= w_winner;
    end
  end

  // A response with nothing outstanding means the cache and this block disagree.
  a_no_resp_when_empty: assert property (@(posedge clk_i) disable iff (reset_i)
                                         cache_v_i |-> !w_fifo_empty);

endmodule

// File: tb/tb_bsg_cache_req_arbiter.sv
// Directed testbench for bsg_cache_req_arbiter: arbitration order, lock, FIFO full,
// response routing, push/pop wrap and mid-operation reset.
module tb_bsg_cache_req_arbiter;

  localparam int N   = 4;
  localparam int PW  = 101;
  localparam int DW  = 64;
  localparam int ELS = 4;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic [N*PW-1:0] req_pkt_i;
  logic [N-1:0]    req_v_i;
  logic [N-1:0]    req_yumi_o;
  logic [DW-1:0]   resp_data_o;
  logic [N-1:0]    resp_v_o;
  logic [N-1:0]    resp_yumi_i;
  logic [PW-1:0]   cache_pkt_o;
  logic            cache_v_o;
  logic            cache_yumi_i;
  logic [DW-1:0]   cache_data_i;
  logic            cache_v_i;
  logic            cache_yumi_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  bsg_cache_req_arbiter #(
    .num_req_p(N), .cache_pkt_width_p(PW), .data_width_p(DW), .tag_fifo_els_p(ELS)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_pkt_i(req_pkt_i), .req_v_i(req_v_i), .req_yumi_o(req_yumi_o),
    .resp_data_o(resp_data_o), .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i),
    .cache_pkt_o(cache_pkt_o), .cache_v_o(cache_v_o), .cache_yumi_i(cache_yumi_i),
    .cache_data_i(cache_data_i), .cache_v_i(cache_v_i), .cache_yumi_o(cache_yumi_o)
  );

  function automatic logic [PW-1:0] pkt_of(input int id);
    return {69'd0, 32'hCAFE_0000 + 32'(id)};
  endfunction

  function automatic logic [N-1:0] onehot(input int id);
    logic [N-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    req_v_i = '0; resp_yumi_i = '0; cache_yumi_i = 1'b0;
    cache_v_i = 1'b0; cache_data_i = '0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    req_v_i = '1; resp_yumi_i = '1; cache_yumi_i = 1'b1;
    cache_v_i = 1'b1; cache_data_i = 64'hDEAD_BEEF_0123_4567;
    tick();
    tick();
    #1;
    n_checks++; if (cache_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_cache_v got=%b exp=0", cache_v_o); end
    n_checks++; if (req_yumi_o !== 4'b0000) begin n_fail++; $display("FAIL reset_req_yumi got=%b exp=0000", req_yumi_o); end
    n_checks++; if (resp_v_o !== 4'b0000) begin n_fail++; $display("FAIL reset_resp_v got=%b exp=0000", resp_v_o); end
    n_checks++; if (cache_yumi_o !== 1'b0) begin n_fail++; $display("FAIL reset_cache_yumi got=%b exp=0", cache_yumi_o); end
    n_checks++; if (resp_data_o !== 64'd0) begin n_fail++; $display("FAIL reset_resp_data got=%h exp=0", resp_data_o); end
    n_checks++; if (cache_pkt_o !== '0) begin n_fail++; $display("FAIL reset_cache_pkt got=%h exp=0", cache_pkt_o); end
    tick();
    reset_i = 1'b0;
    idle_inputs();
    #1;
    n_checks++; if (cache_v_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle_cache_v got=%b exp=0", cache_v_o); end
    $display("txn reset done");
  endtask

  task automatic test_round_robin();
    int q[$];
    int exp_id;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      exp_id = k % N;
      req_v_i = '1; cache_yumi_i = 1'b1; resp_yumi_i = '1;
      cache_v_i = (q.size() > 0);
      cache_data_i = 64'(100 + k);
      #1;
      n_checks++; if (req_yumi_o !== onehot(exp_id)) begin n_fail++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_yumi_o, onehot(exp_id)); end
      n_checks++; if (cache_pkt_o !== pkt_of(exp_id)) begin n_fail++; $display("FAIL rr_pkt k=%0d got=%h exp=%h", k, cache_pkt_o, pkt_of(exp_id)); end
      if (q.size() > 0) begin
        n_checks++; if (resp_v_o !== onehot(q[0])) begin n_fail++; $display("FAIL rr_resp_v k=%0d got=%b exp=%b", k, resp_v_o, onehot(q[0])); end
        n_checks++; if (resp_data_o !== 64'(100 + k)) begin n_fail++; $display("FAIL rr_resp_data k=%0d got=%0d exp=%0d", k, resp_data_o, 100 + k); end
      end
      $display("txn rr k=%0d grant=%b resp_v=%b", k, req_yumi_o, resp_v_o);
      tick();
      if (q.size() > 0) void'(q.pop_front());
      q.push_back(exp_id);
    end
    idle_inputs();
  endtask

  task automatic test_lock();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req_v_i = (k == 3) ? 4'b0101 : 4'b0100;
      cache_yumi_i = 1'b0;
      #1;
      n_checks++; if (cache_v_o !== 1'b1) begin n_fail++; $display("FAIL lock_cache_v k=%0d got=%b exp=1", k, cache_v_o); end
      n_checks++; if (cache_pkt_o !== pkt_of(2)) begin n_fail++; $display("FAIL lock_pkt k=%0d got=%h exp=%h", k, cache_pkt_o, pkt_of(2)); end
      n_checks++; if (req_yumi_o !== 4'b0000) begin n_fail++; $display("FAIL lock_no_yumi k=%0d got=%b exp=0000", k, req_yumi_o); end
      tick();
    end
    req_v_i = 4'b0101; cache_yumi_i = 1'b1;
    #1;
    n_checks++; if (req_yumi_o !== 4'b0100) begin n_fail++; $display("FAIL lock_accept got=%b exp=0100", req_yumi_o); end
    n_checks++; if (cache_pkt_o !== pkt_of(2)) begin n_fail++; $display("FAIL lock_accept_pkt got=%h exp=%h", cache_pkt_o, pkt_of(2)); end
    $display("txn lock accept grant=%b", req_yumi_o);
    tick();
    req_v_i = 4'b0001;
    #1;
    n_checks++; if (req_yumi_o !== 4'b0001) begin n_fail++; $display("FAIL lock_next_grant got=%b exp=0001", req_yumi_o); end
    n_checks++; if (cache_pkt_o !== pkt_of(0)) begin n_fail++; $display("FAIL lock_next_pkt got=%h exp=%h", cache_pkt_o, pkt_of(0)); end
    $display("txn lock next grant=%b", req_yumi_o);
    tick();
    idle_inputs();
  endtask

  task automatic test_fifo_full();
    do_reset();
    req_v_i = '1; cache_yumi_i = 1'b1; resp_yumi_i = '0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (req_yumi_o !== onehot(k)) begin n_fail++; $display("FAIL full_fill k=%0d got=%b exp=%b", k, req_yumi_o, onehot(k)); end
      tick();
    end
    #1;
    n_checks++; if (cache_v_o !== 1'b0) begin n_fail++; $display("FAIL full_block got=%b exp=0", cache_v_o); end
    tick();
    cache_v_i = 1'b1; cache_data_i = 64'h55; resp_yumi_i = '1;
    #1;
    n_checks++; if (resp_v_o !== 4'b0001) begin n_fail++; $display("FAIL full_pop_resp_v got=%b exp=0001", resp_v_o); end
    n_checks++; if (cache_yumi_o !== 1'b1) begin n_fail++; $display("FAIL full_pop_yumi got=%b exp=1", cache_yumi_o); end
    n_checks++; if (cache_v_o !== 1'b0) begin n_fail++; $display("FAIL full_pop_same_cycle got=%b exp=0", cache_v_o); end
    tick();
    cache_v_i = 1'b0; resp_yumi_i = '0;
    #1;
    n_checks++; if (req_yumi_o !== 4'b0001) begin n_fail++; $display("FAIL full_fifth_issue got=%b exp=0001", req_yumi_o); end
    $display("txn full fifth grant=%b", req_yumi_o);
    tick();
    #1;
    n_checks++; if (cache_v_o !== 1'b0) begin n_fail++; $display("FAIL full_again got=%b exp=0", cache_v_o); end
    idle_inputs();
  endtask

  task automatic test_routing();
    int ids[3] = '{3, 1, 3};
    logic [DW-1:0] dat[3] = '{64'hA, 64'hB, 64'hC};
    do_reset();
    cache_yumi_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_v_i = onehot(ids[k]);
      #1;
      n_checks++; if (req_yumi_o !== onehot(ids[k])) begin n_fail++; $display("FAIL route_issue k=%0d got=%b exp=%b", k, req_yumi_o, onehot(ids[k])); end
      tick();
    end
    req_v_i = '0; cache_yumi_i = 1'b0;
    cache_v_i = 1'b1; cache_data_i = dat[0]; resp_yumi_i = 4'b0111;
    #1;
    n_checks++; if (cache_yumi_o !== 1'b0) begin n_fail++; $display("FAIL route_wrong_yumi got=%b exp=0", cache_yumi_o); end
    tick();
    for (int k = 0; k < 3; k++) begin
      cache_v_i = 1'b1; cache_data_i = dat[k]; resp_yumi_i = '1;
      #1;
      n_checks++; if (resp_v_o !== onehot(ids[k])) begin n_fail++; $display("FAIL route_resp_v k=%0d got=%b exp=%b", k, resp_v_o, onehot(ids[k])); end
      n_checks++; if (resp_data_o !== dat[k]) begin n_fail++; $display("FAIL route_resp_data k=%0d got=%h exp=%h", k, resp_data_o, dat[k]); end
      n_checks++; if (cache_yumi_o !== 1'b1) begin n_fail++; $display("FAIL route_cache_yumi k=%0d got=%b exp=1", k, cache_yumi_o); end
      $display("txn route k=%0d resp_v=%b data=%h", k, resp_v_o, resp_data_o);
      tick();
    end
    cache_v_i = 1'b0;
    #1;
    n_checks++; if (resp_v_o !== 4'b0000) begin n_fail++; $display("FAIL route_idle got=%b exp=0000", resp_v_o); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int q[$];
    int grant;
    do_reset();
    req_v_i = '1; cache_yumi_i = 1'b1;
    tick();
    tick();
    q.push_back(0); q.push_back(1);
    for (int k = 0; k < 10; k++) begin
      grant = (k + 2) % N;
      cache_v_i = 1'b1; cache_data_i = 64'(200 + k); resp_yumi_i = '1;
      #1;
      n_checks++; if (req_yumi_o !== onehot(grant)) begin n_fail++; $display("FAIL b2b_grant k=%0d got=%b exp=%b", k, req_yumi_o, onehot(grant)); end
      n_checks++; if (resp_v_o !== onehot(q[0])) begin n_fail++; $display("FAIL b2b_resp_v k=%0d got=%b exp=%b", k, resp_v_o, onehot(q[0])); end
      $display("txn b2b k=%0d grant=%b resp_v=%b", k, req_yumi_o, resp_v_o);
      tick();
      void'(q.pop_front());
      q.push_back(grant);
    end
    cache_v_i = 1'b0; resp_yumi_i = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (cache_v_o !== (k < 2)) begin n_fail++; $display("FAIL b2b_refill k=%0d got=%b exp=%b", k, cache_v_o, (k < 2)); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_v_i = '1; cache_yumi_i = 1'b1;
    tick(); tick(); tick();
    reset_i = 1'b1; cache_v_i = 1'b1; resp_yumi_i = '1;
    tick();
    #1;
    n_checks++; if ({cache_v_o, cache_yumi_o, req_yumi_o, resp_v_o} !== 10'd0) begin n_fail++; $display("FAIL mid_reset_outputs got=%b exp=0", {cache_v_o, cache_yumi_o, req_yumi_o, resp_v_o}); end
    reset_i = 1'b0; cache_v_i = 1'b0; resp_yumi_i = '0;
    req_v_i = 4'b1010; cache_yumi_i = 1'b1;
    #1;
    n_checks++; if (req_yumi_o !== 4'b0010) begin n_fail++; $display("FAIL mid_reset_first_grant got=%b exp=0010", req_yumi_o); end
    $display("txn post-reset grant=%b", req_yumi_o);
    tick();
    req_v_i = '0; cache_yumi_i = 1'b0;
    cache_v_i = 1'b1; cache_data_i = 64'h77; resp_yumi_i = '1;
    #1;
    n_checks++; if (resp_v_o !== 4'b0010) begin n_fail++; $display("FAIL mid_reset_head got=%b exp=0010", resp_v_o); end
    tick();
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < N; i++) req_pkt_i[i*PW +: PW] = pkt_of(i);
    reset_i = 1'b1;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_lock();
    test_fifo_full();
    test_routing();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
